// File: rtl/sroc_ctrl_pkg.sv
// Shared state encoding and constants for the SROC sync controller.
package sroc_ctrl_pkg;

  localparam int RELOCK_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_WAIT_HB = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAULT   = 3'd5
  } sroc_state_e;

  // Heartbeats nominally arrive once per second; allow 10% slack.
  function automatic int unsigned sroc_default_timeout(input int unsigned sysclk_hz);
    logic [63:0] t;
    t = (64'(sysclk_hz) * 64'd11) / 64'd10;
    return t[31:0];
  endfunction

endpackage

// File: rtl/sroc_sync_bit.sv
// Two-flop synchroniser. With EDGE_EN set, the output is instead a registered
// one-cycle pulse on the synchronised rising edge (three cycles after the input rises).
module sroc_sync_bit #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= sync_q;
          rise_q <= sync_q & ~prev_q;
        end
      end
      assign q_o = rise_q;
    end else begin : g_level
      assign q_o = sync_q;
    end
  endgenerate

endmodule

// File: rtl/sroc_sync_controller.sv
// Applies SROC divisor changes and supervises generator lock against EVR heartbeats.
// Define SROC_SYNC_IRQ_EN to add the lockLostIrq output.
module sroc_sync_controller
  import sroc_ctrl_pkg::*;
#(
  parameter int unsigned SYSCLK_FREQUENCY = 100000000,
  parameter int unsigned DIVISOR_WIDTH    = 10,
  parameter int unsigned HB_CONFIRM       = 2,
  parameter int unsigned SETTLE_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES   = sroc_default_timeout(SYSCLK_FREQUENCY)
) (
  input  logic                          sysClk,
  input  logic                          sysRst_n,
  input  logic                          cfgStrobe,
  input  logic [DIVISOR_WIDTH-1:0]      cfgDivisor,
  input  logic                          evrHeartbeatMarker,
  input  logic                          evrSROCsynced,
  input  logic                          heartBeatValid,
  output logic                          divisorStrobe,
  output logic [DIVISOR_WIDTH-1:0]      divisorValue,
  output logic                          locked,
  output logic                          fault,
  output logic [2:0]                    state,
  output logic [RELOCK_COUNT_WIDTH-1:0] relockCount
`ifdef SROC_SYNC_IRQ_EN
  ,
  output logic                          lockLostIrq
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0] CONFIRM_TARGET = 4'(HB_CONFIRM);
  localparam logic [RELOCK_COUNT_WIDTH-1:0] RELOCK_MAX = '1;

  logic hb_edge;
  logic synced;

  sroc_sync_bit #(.EDGE_EN(1'b1)) u_sync_hb (
    .clk   (sysClk),
    .rst_n (sysRst_n),
    .d_i   (evrHeartbeatMarker),
    .q_o   (hb_edge)
  );

  sroc_sync_bit #(.EDGE_EN(1'b0)) u_sync_synced (
    .clk   (sysClk),
    .rst_n (sysRst_n),
    .d_i   (evrSROCsynced),
    .q_o   (synced)
  );

  sroc_state_e                   state_q, state_d;
  logic [DIVISOR_WIDTH-1:0]      div_q, div_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]               inval_cnt_q, inval_cnt_d;
  logic [SC_W-1:0]               settle_q, settle_d;
  logic [3:0]                    confirm_q, confirm_d;
  logic                          pend_q, pend_d;
  logic [RELOCK_COUNT_WIDTH-1:0] relock_q, relock_d;
  logic                          strobe_q, locked_q, fault_q;
  logic                          timed_out, starved;
  logic [3:0]                    confirm_inc;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    to_cnt_d    = to_cnt_q;
    inval_cnt_d = inval_cnt_q;
    settle_d    = settle_q;
    confirm_d   = confirm_q;
    pend_d      = pend_q;
    relock_d    = relock_q;
    timed_out   = (to_cnt_q == TO_LAST);
    starved     = !heartBeatValid && (inval_cnt_q == TO_LAST);
    confirm_inc = confirm_q + 4'd1;

    // Heartbeat-gap and valid-loss counters only run while supervising lock.
    if (state_q == ST_WAIT_HB || state_q == ST_SETTLE || state_q == ST_LOCKED) begin
      if (!timed_out) to_cnt_d = to_cnt_q + 1'b1;
      if (heartBeatValid) inval_cnt_d = '0;
      else if (inval_cnt_q != TO_LAST) inval_cnt_d = inval_cnt_q + 1'b1;
    end else begin
      to_cnt_d    = '0;
      inval_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_APPLY: begin
        state_d   = ST_WAIT_HB;
        confirm_d = '0;
      end
      ST_WAIT_HB: begin
        if (hb_edge) begin
          state_d  = ST_SETTLE;
          to_cnt_d = '0;
          settle_d = '0;
        end else if (timed_out || starved) begin
          state_d = ST_FAULT;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          if (synced) begin
            confirm_d = confirm_inc;
            pend_d    = 1'b0;
            state_d   = (confirm_inc >= CONFIRM_TARGET) ? ST_LOCKED : ST_WAIT_HB;
          end else begin
            confirm_d = '0;
            state_d   = ST_WAIT_HB;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!heartBeatValid || timed_out) begin
          state_d = ST_FAULT;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          if (settle_q == SETTLE_LAST) begin
            pend_d = 1'b0;
            if (!synced) begin
              state_d   = ST_WAIT_HB;
              confirm_d = '0;
              if (relock_q != RELOCK_MAX) relock_d = relock_q + 1'b1;
            end
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end else if (hb_edge) begin
          pend_d   = 1'b1;
          settle_d = '0;
          to_cnt_d = '0;
        end
      end
      ST_FAULT: begin
        if (heartBeatValid && hb_edge) begin
          state_d   = ST_SETTLE;
          confirm_d = '0;
          settle_d  = '0;
          to_cnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new divisor request overrides every other event except an update in flight.
    if (cfgStrobe && state_q != ST_APPLY) begin
      state_d = ST_APPLY;
      div_d   = cfgDivisor;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      to_cnt_q    <= '0;
      inval_cnt_q <= '0;
      settle_q    <= '0;
      confirm_q   <= '0;
      pend_q      <= 1'b0;
      relock_q    <= '0;
      strobe_q    <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      to_cnt_q    <= to_cnt_d;
      inval_cnt_q <= inval_cnt_d;
      settle_q    <= settle_d;
      confirm_q   <= confirm_d;
      pend_q      <= pend_d;
      relock_q    <= relock_d;
      strobe_q    <= (state_d == ST_APPLY);
      locked_q    <= (state_d == ST_LOCKED);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

`ifdef SROC_SYNC_IRQ_EN
  logic irq_q;

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state_q == ST_LOCKED) &&
               (state_d == ST_WAIT_HB || state_d == ST_FAULT);
    end
  end

  assign lockLostIrq = irq_q;
`endif

  assign divisorStrobe = strobe_q;
  assign divisorValue  = div_q;
  assign locked        = locked_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign relockCount   = relock_q;

endmodule
